// File: rtl/parking_lot_pkg.sv
// Shared state encoding and seven-segment helpers for the multi-gate parking-lot counter.
package parking_lot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_BA,
        OUT_A
    } gate_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int BIN_W = 14;
    localparam int BCD_W = 16;

    // {g,f,e,d,c,b,a}, active-low; non-decimal codes blank the digit
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] bin);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = BIN_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[BCD_W-2:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/parking_lot_multi_gate_counter_gate_direction_fsm.sv
// One gate: synchronise and debounce both beams, then decode the beam order into enter/exit pulses.
module gate_direction_fsm #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic enter_pulse,
    output logic exit_pulse
);
    import parking_lot_pkg::*;

    localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]        sync_p0;
    logic [1:0]        sync_p1;
    logic [1:0]        deb_p2;
    logic [STAB_W-1:0] stab [2];
    gate_state_t       state;

    // Stage p0/p1: two-flop synchroniser; p2: debounced {a,b}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            for (int i = 0; i < 2; i++) stab[i] <= '0;
        end else begin
            sync_p0 <= {sensor_a, sensor_b};
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb_p2[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == STAB_LAST) begin
                    deb_p2[i] <= sync_p1[i];
                    stab[i]   <= '0;
                end else begin
                    stab[i] <= stab[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: direction FSM; 00 always returns to IDLE, completing a pass only from IN_B/OUT_A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            if (deb_p2 == 2'b00) begin
                state       <= IDLE;
                enter_pulse <= (state == IN_B);
                exit_pulse  <= (state == OUT_A);
            end else begin
                case (state)
                    IDLE: begin
                        if (deb_p2 == 2'b10)      state <= IN_A;
                        else if (deb_p2 == 2'b01) state <= OUT_B;
                    end
                    IN_A:   if (deb_p2 == 2'b11) state <= IN_AB;
                    IN_AB: begin
                        if (deb_p2 == 2'b01)      state <= IN_B;
                        else if (deb_p2 == 2'b10) state <= IN_A;
                    end
                    IN_B:   if (deb_p2 == 2'b11) state <= IN_AB;
                    OUT_B:  if (deb_p2 == 2'b11) state <= OUT_BA;
                    OUT_BA: begin
                        if (deb_p2 == 2'b10)      state <= OUT_A;
                        else if (deb_p2 == 2'b01) state <= OUT_B;
                    end
                    OUT_A:  if (deb_p2 == 2'b11) state <= OUT_BA;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/parking_lot_multi_gate_counter.sv
// Multi-gate occupancy counter: per-gate direction decoders, saturating count and 4-digit display.
module parking_lot_multi_gate_counter #(
    parameter int NUM_GATES       = 2,
    parameter int CAPACITY        = 99,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REFRESH_CYCLES  = 100000,
    parameter int COUNT_W         = $clog2(CAPACITY + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_GATES-1:0] sensor_a_i,
    input  logic [NUM_GATES-1:0] sensor_b_i,
    output logic [COUNT_W-1:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 reject_o,
    output logic [6:0]           seven_segment_o,
    output logic [3:0]           an_o
);
    import parking_lot_pkg::*;

    // Headroom for count + 8 entries or count - 8 exits, plus sign
    localparam int CAND_W = COUNT_W + 5;
    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    logic [NUM_GATES-1:0]       enter_p0;
    logic [NUM_GATES-1:0]       exit_p0;
    logic signed [CAND_W-1:0]   cand_p0;
    logic [COUNT_W-1:0]         count_next;
    logic                       reject_next;
    logic [COUNT_W-1:0]         count_p1;
    logic                       full_p1;
    logic                       empty_p1;
    logic                       reject_p1;
    logic [REF_W-1:0]           refresh_cnt;
    logic [1:0]                 digit;
    logic [BCD_W-1:0]           bcd;
    logic [6:0]                 seg_p2;
    logic [3:0]                 an_p2;

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_direction_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_gate (
            .clk        (clk_i),
            .rst_n      (reset_ni),
            .sensor_a   (sensor_a_i[g]),
            .sensor_b   (sensor_b_i[g]),
            .enter_pulse(enter_p0[g]),
            .exit_pulse (exit_p0[g])
        );
    end

    // Returns {reject, clamped count}
    function automatic logic [COUNT_W:0] saturate(input logic signed [CAND_W-1:0] cand);
        if (cand > $signed(CAND_W'(CAPACITY))) return {1'b1, COUNT_W'(CAPACITY)};
        if (cand < 0)                          return {1'b1, {COUNT_W{1'b0}}};
        return {1'b0, cand[COUNT_W-1:0]};
    endfunction

    always_comb begin
        cand_p0 = $signed(CAND_W'(count_p1));
        for (int g = 0; g < NUM_GATES; g++) begin
            cand_p0 = cand_p0 + $signed(CAND_W'(enter_p0[g])) - $signed(CAND_W'(exit_p0[g]));
        end
        {reject_next, count_next} = saturate(cand_p0);
    end

    // Stage p1: registered occupancy and status
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_p1  <= '0;
            full_p1   <= 1'b0;
            empty_p1  <= 1'b1;
            reject_p1 <= 1'b0;
        end else begin
            count_p1  <= count_next;
            reject_p1 <= reject_next;
            full_p1   <= (count_next == COUNT_W'(CAPACITY));
            empty_p1  <= (count_next == '0);
        end
    end

    assign bcd = bin_to_bcd(BIN_W'(count_p1));

    // Stage p2: anode and segments registered together so digits never ghost
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            refresh_cnt <= '0;
            digit       <= 2'd0;
            an_p2       <= 4'b1110;
            seg_p2      <= 7'b1000000;
        end else begin
            if (refresh_cnt == REF_LAST) begin
                refresh_cnt <= '0;
                digit       <= digit + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an_p2  <= ~(4'b0001 << digit);
            seg_p2 <= bcd_to_seg(bcd[{digit, 2'b00} +: 4]);
        end
    end

    assign count_o         = count_p1;
    assign full_o          = full_p1;
    assign empty_o         = empty_p1;
    assign reject_o        = reject_p1;
    assign seven_segment_o = seg_p2;
    assign an_o            = an_p2;

endmodule

// File: tb/tb_parking_lot_multi_gate_counter.sv
// Directed scenarios; expected occupancy updates are queued by the stimulus and consumed by a monitor.
module tb_parking_lot_multi_gate_counter;

    localparam int NG  = 2;
    localparam int CAP = 3;
    localparam int DEB = 2;
    localparam int REF = 4;
    localparam int CW  = 2;
    localparam int LAT = 2 + DEB + 2;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_3 = 7'b0110000;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic [NG-1:0] sensor_a_i;
    logic [NG-1:0] sensor_b_i;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          reject_o;
    logic [6:0]    seven_segment_o;
    logic [3:0]    an_o;

    parking_lot_multi_gate_counter #(
        .NUM_GATES      (NG),
        .CAPACITY       (CAP),
        .DEBOUNCE_CYCLES(DEB),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .sensor_a_i     (sensor_a_i),
        .sensor_b_i     (sensor_b_i),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .reject_o       (reject_o),
        .seven_segment_o(seven_segment_o),
        .an_o           (an_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int count;
        int reject;
        int full;
        int empty;
        int at;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input int cnt, input int rej, input int at);
        exp_t e;
        e.count  = cnt;
        e.reject = rej;
        e.full   = (cnt == CAP) ? 1 : 0;
        e.empty  = (cnt == 0) ? 1 : 0;
        e.at     = at;
        sb.push_back(e);
    endtask

    // Occupancy monitor: any count change or reject pulse is an output event
    int   prev_count = 0;
    exp_t got;
    always @(negedge clk) begin
        if (!reset_ni) begin
            prev_count = 0;
        end else begin
            if (int'(count_o) != prev_count || reject_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: count %0d reject %0b, none expected (cycle %0d)",
                             count_o, reject_o, cyc);
                end else begin
                    got = sb.pop_front();
                    check("count", int'(count_o), got.count);
                    check("reject", int'(reject_o), got.reject);
                    check("full", int'(full_o), got.full);
                    check("empty", int'(empty_o), got.empty);
                    check("event_cycle", cyc, got.at);
                end
            end
            prev_count = int'(count_o);
        end
    end

    // Display monitor: mode 1 checks the digit rotation after reset, mode 2 a steady ones digit
    int         disp_mode = 0;
    int         rel0 = 0;
    int         k;
    logic [6:0] disp_seg = SEG_0;
    logic [3:0] want_an;
    always @(negedge clk) begin
        if (reset_ni && disp_mode == 1) begin
            k = cyc - rel0;
            if (k >= 1) begin
                want_an = ~(4'b0001 << (((k - 1) / REF) % 4));
                check("an_rotation", int'(an_o), int'(want_an));
                check("seg_zero", int'(seven_segment_o), int'(SEG_0));
            end
        end else if (reset_ni && disp_mode == 2) begin
            if (an_o == 4'b1110) check("seg_ones", int'(seven_segment_o), int'(disp_seg));
            else                 check("seg_upper", int'(seven_segment_o), int'(SEG_0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_gate(input int g, input logic [1:0] ab);
        sensor_a_i[g] = ab[1];
        sensor_b_i[g] = ab[0];
    endtask

    task automatic check_reset_values();
        check("rst_count", int'(count_o), 0);
        check("rst_empty", int'(empty_o), 1);
        check("rst_full", int'(full_o), 0);
        check("rst_reject", int'(reject_o), 0);
        check("rst_an", int'(an_o), 4'b1110);
        check("rst_seg", int'(seven_segment_o), int'(SEG_0));
    endtask

    // Full pass through one gate; optional one-cycle drop of beam a while in the final a-only phase
    task automatic car(input int g, input bit entering, input bit evt, input int cnt,
                       input int rej, input bit glitch);
        set_gate(g, entering ? 2'b10 : 2'b01); tick(8);
        set_gate(g, 2'b11);                    tick(8);
        set_gate(g, entering ? 2'b01 : 2'b10); tick(8);
        if (glitch) begin
            sensor_a_i[g] = 1'b0; tick(1);
            sensor_a_i[g] = 1'b1; tick(8);
        end
        set_gate(g, 2'b00);
        if (evt) push(cnt, rej, cyc + LAT);
        tick(10);
    endtask

    initial begin
        reset_ni   = 1'b0;
        sensor_a_i = '0;
        sensor_b_i = '0;
        tick(3);
        check_reset_values();

        reset_ni  = 1'b1;
        rel0      = cyc;
        disp_mode = 1;
        tick(20);
        disp_mode = 0;

        car(0, 1'b1, 1'b1, 1, 0, 1'b0);

        // Car backs out of gate 0, with a short beam-a dropout while both beams are blocked
        set_gate(0, 2'b10); tick(8);
        set_gate(0, 2'b11); tick(8);
        sensor_a_i[0] = 1'b0; tick(1);
        sensor_a_i[0] = 1'b1; tick(8);
        set_gate(0, 2'b10); tick(8);
        set_gate(0, 2'b00); tick(12);

        car(1, 1'b1, 1'b1, 2, 0, 1'b0);
        car(0, 1'b1, 1'b1, 3, 0, 1'b0);
        car(1, 1'b1, 1'b1, 3, 1, 1'b0);

        disp_seg  = SEG_3;
        disp_mode = 2;
        tick(12);
        disp_mode = 0;

        car(0, 1'b0, 1'b1, 2, 0, 1'b0);

        // Entry on gate 0 and exit on gate 1 complete in the same cycle
        set_gate(0, 2'b10); set_gate(1, 2'b01); tick(8);
        set_gate(0, 2'b11); set_gate(1, 2'b11); tick(8);
        set_gate(0, 2'b01); set_gate(1, 2'b10); tick(8);
        set_gate(0, 2'b00); set_gate(1, 2'b00); tick(12);

        car(1, 1'b0, 1'b1, 1, 0, 1'b1);
        car(0, 1'b0, 1'b1, 0, 0, 1'b0);
        car(1, 1'b0, 1'b1, 0, 1, 1'b0);
        car(0, 1'b1, 1'b1, 1, 0, 1'b0);

        // Reset while gate 0 is between the beams; the rest of the pass must not count
        set_gate(0, 2'b10); tick(8);
        set_gate(0, 2'b11); tick(8);
        reset_ni = 1'b0;
        #1;
        check_reset_values();
        tick(3);
        reset_ni = 1'b1;
        tick(10);
        set_gate(0, 2'b01); tick(8);
        set_gate(0, 2'b00); tick(12);

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_lot_multi_gate_counter.md
Name: parking_lot_multi_gate_counter

Overview:
Parametrised successor to the single-gate parking-lot occupancy counter. Monitors NUM_GATES gates, each with an outer sensor (a) and an inner sensor (b). Each sensor is synchronised and debounced, then decoded by a per-gate direction FSM into enter/exit events. A saturating occupancy count is held against CAPACITY, with full/empty/reject status. The count is shown in decimal on a 4-digit multiplexed seven-segment display; this block is the top level of the board build.

Parameters:
NUM_GATES, 2, number of independent gates (1..8)
CAPACITY, 99, maximum occupancy (1..9999)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a sensor change (>=1)
REFRESH_CYCLES, 100000, clock cycles each display digit is driven (>=1)
COUNT_W, $clog2(CAPACITY+1), occupancy width (derived)

Ports:
clk_i  input  1  system clock
reset_ni  input  1  asynchronous active-low reset
sensor_a_i  input  NUM_GATES  outer sensors, 1 = beam blocked, asynchronous
sensor_b_i  input  NUM_GATES  inner sensors, 1 = beam blocked, asynchronous
count_o  output  COUNT_W  current occupancy
full_o  output  1  count_o == CAPACITY
empty_o  output  1  count_o == 0
reject_o  output  1  one-cycle pulse: one or more events dropped by saturation this update
seven_segment_o  output  7  {g,f,e,d,c,b,a}, active-low
an_o  output  4  digit enables, active-low, an_o[0] = ones digit

Behaviour:
Reset and clocking:
- One clock domain; reset is asynchronous and active-low.
- On reset: count_o=0, empty_o=1, full_o=0, reject_o=0, all gate FSMs IDLE, debounced sensors=0, digit index=0, an_o=4'b1110, seven_segment_o=7'b1000000 (shows "0").
- Reset asserted mid-sequence abandons all partial gate sequences; no event is generated.

Sensor conditioning (per sensor):
- 2-FF synchroniser feeds a stability counter.
- Debounced value takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples that differ from it.
- Pin-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Glitches shorter than DEBOUNCE_CYCLES samples are ignored.

Gate FSM (per gate, on debounced {a,b}):
- States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A.
- IDLE: 10 -> IN_A; 01 -> OUT_B; 11 or 00 -> stay.
- IN_A: 11 -> IN_AB; 00 -> IDLE (car backed out).
- IN_AB: 01 -> IN_B; 10 -> IN_A.
- IN_B: 00 -> IDLE and assert enter for one cycle; 11 -> IN_AB.
- OUT_* states mirror IN_* with a and b swapped; OUT_A -> IDLE on 00 asserts exit.
- Any input not listed for a state holds that state, except 00, which always returns to IDLE with no event.
- enter/exit are registered: they assert in the cycle after the transition is taken.

Occupancy update:
- Each cycle: E = popcount(enter), X = popcount(exit).
- Candidate = count + E - X, computed signed and wide enough for the extremes.
- Candidate > CAPACITY -> count = CAPACITY, reject_o = 1.
- Candidate < 0 -> count = 0, reject_o = 1.
- Otherwise count = candidate. Simultaneous enter and exit on different gates net out, with no reject.
- count_o, full_o, empty_o and reject_o are all registered; count_o changes one cycle after the enter/exit pulse.

Display:
- Digit counter advances every REFRESH_CYCLES cycles and wraps 3 -> 0.
- Drive an_o low for the selected digit only.
- Digits come from a combinational binary-to-BCD conversion (double-dabble) of count_o.
- Leading zeros are shown.
- seven_segment_o is registered together with an_o, so there is no ghosting between digits.

Decomposition:
- Package parking_lot_pkg: gate_state_t enum; function bcd_to_seg (4-bit -> 7-bit active-low); segment constant for blank.
- Sub-module gate_direction_fsm: one sensor pair in; debounce, FSM and enter/exit pulses out. Instantiated NUM_GATES times in a generate loop.
- Top level holds the occupancy arithmetic and the display mux.

Test Plan:
Bench settings: NUM_GATES=2, CAPACITY=3, DEBOUNCE_CYCLES=2, REFRESH_CYCLES=4; each sensor level held >= 8 cycles.
- Reset, then release: count_o=0, empty_o=1, an_o cycles 1110->1101->1011->0111 every 4 cycles, seven_segment_o=7'b1000000 on every digit.
- Gate 0 drives a,b as 10,11,01,00: count_o=1 exactly 1 cycle after enter pulse; empty_o=0.
- Gate 0 drives 10,11,10,00 (car backs out): count_o unchanged; 1-cycle 1->0 glitch on sensor_a has no effect.
- Three entries then a fourth on gate 1: count_o=3, full_o=1; fourth gives reject_o=1 for one cycle and count_o stays 3.
- Gate 0 entry and gate 1 exit completing in the same cycle at count 2: count_o stays 2, reject_o=0. Exit when count=0: reject_o=1, count_o stays 0.
- Assert reset_ni low while gate 0 is in IN_AB: all outputs return to reset values immediately; after release, completing 01,00 produces no event.
